// File: rtl/strb_bus_master.sv
// strb_bus_master
//   Initiator for the 5-bit address + strobe register/direction select bus.
//   Requests arrive on a valid/ready port and wait in a small FIFO. Each one
//   is then played onto the bus as a setup / strobe / hold sequence, so the
//   decoder always sees a stable address around a clean strobe pulse.
//
// Handshake: a request is taken on any rising clk edge where
//   req_valid && req_ready. req_ready depends only on the FIFO level (it is
//   high whenever the FIFO is not full) and never combinationally on req_valid.
//
// Ports
//   clk, rst     : single clock, synchronous active-high reset
//   req_valid    : request present
//   req_ready    : FIFO not full
//   req_addr[4:0]: bus address (bit 4 bank select, bits 3:0 index), passed through unaltered
//   bus_addr[4:0]: registered address to the decoder
//   bus_strb     : registered strobe to the decoder
//   busy         : FSM not IDLE or FIFO not empty
//   done         : one-cycle pulse on the final cycle of each transaction
//   fifo_level   : current FIFO occupancy
//
// Optional build macro STRB_BUS_MASTER_TXCNT_EN adds:
//   cnt_clr      : synchronous clear of tx_count (wins over an increment)
//   tx_count[15:0]: wrapping count of done pulses
module strb_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [4:0]                  req_addr,
  output logic [4:0]                  bus_addr,
  output logic                        bus_strb,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef STRB_BUS_MASTER_TXCNT_EN
  ,
  input  logic                        cnt_clr,
  output logic [15:0]                 tx_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  // Terminal counts for each timed phase. HOLD_LAST is unused when HOLD_CYC=0.
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          push;
  logic          pop;

  assign req_ready  = (level != FULL_LEVEL);
  assign push       = req_valid && req_ready;
  assign pop        = (state == IDLE) && (level != '0);
  assign fifo_level = level;
  assign busy       = (state != IDLE) || (level != '0);

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_addr;
  end

  // FIFO pointers and level. Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sequencer. done is registered, so it is raised on the edge that enters
  // the final cycle of the transaction (last strobe cycle when HOLD_CYC=0,
  // otherwise last hold cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bus_addr <= '0;
      bus_strb <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            bus_addr <= mem[rd_ptr];
            cnt      <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt      <= '0;
            state    <= STROBE;
            bus_strb <= 1'b1;
            done     <= (STROBE_CYC == 1) && (HOLD_CYC == 0);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STROBE: begin
          if (cnt == STROBE_LAST) begin
            cnt      <= '0;
            bus_strb <= 1'b0;
            if (HOLD_CYC == 0) begin
              state <= IDLE;
            end else begin
              state <= HOLD;
              done  <= (HOLD_CYC == 1);
            end
          end else begin
            cnt  <= cnt + 8'd1;
            done <= (HOLD_CYC == 0) && (cnt + 8'd1 == STROBE_LAST);
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt  <= cnt + 8'd1;
            done <= (cnt + 8'd1 == HOLD_LAST);
          end
        end
        default: begin
          state    <= IDLE;
          bus_strb <= 1'b0;
        end
      endcase
    end
  end

`ifdef STRB_BUS_MASTER_TXCNT_EN
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) tx_count <= '0;
    else if (done)      tx_count <= tx_count + 16'd1;
  end
`endif

endmodule

// File: doc/strb_bus_master.md
Name: strb_bus_master

Overview:
- Initiator side of the 5-bit address + strobe register/direction select bus; drives the bus that the common register/direction decoder consumes.
- Accepts write-select requests from control logic through a valid/ready interface and buffers them in a small FIFO.
- Each request is serialised onto the bus as a timed setup/strobe/hold sequence, so the decoder sees a stable address around a clean strobe pulse.

Parameters:
- SETUP_CYC, 1, cycles the address is stable before the strobe rises; legal range 1..255.
- STROBE_CYC, 2, strobe high width in cycles; legal range 1..255.
- HOLD_CYC, 1, cycles the address is held after the strobe falls; legal range 0..255.
- FIFO_DEPTH, 4, request buffer depth; power of 2, 2..16.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full; the request is accepted when req_valid && req_ready at a clk edge.
- req_addr  in  5  bus address. Bit 4 is the register/direction bank select; bits 3:0 are the index. Passed through to the bus unaltered.
- bus_addr  out  5  address to the decoder (data_in).
- bus_strb  out  1  strobe to the decoder (strob_in).
- busy  out  1  FSM not IDLE, or FIFO not empty.
- done  out  1  one-cycle pulse on the final cycle of each transaction.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (synchronous, rst high at clk edge):
  - FSM goes to IDLE; FIFO is emptied.
  - bus_addr=0, bus_strb=0, done=0, busy=0, fifo_level=0, req_ready=1.
- FIFO:
  - Push occurs on an accepted request; pop occurs when the FSM is in IDLE and the FIFO is non-empty.
  - Simultaneous push and pop leaves the level unchanged.
  - When full, req_ready=0 and req_valid is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - No combinational path from req_valid to req_ready; ready depends on level only.
- FSM states and transitions:
  - IDLE: bus_strb=0, bus_addr holds its last value. If the FIFO is non-empty, pop, load bus_addr with the head entry, clear the cycle counter, and go to SETUP.
  - SETUP: bus_strb=0. Lasts SETUP_CYC cycles, then go to STROBE.
  - STROBE: bus_strb=1. Lasts STROBE_CYC cycles. Then go to HOLD, or to IDLE with done=1 on the last strobe cycle if HOLD_CYC=0.
  - HOLD: bus_strb=0, bus_addr unchanged. Lasts HOLD_CYC cycles. done=1 on the last HOLD cycle, then go to IDLE.
- Timing guarantees:
  - bus_addr is registered and changes only on the IDLE->SETUP transition.
  - bus_strb is registered and glitch-free; it never rises in the same cycle that bus_addr changes.
- Latency: a request accepted into an empty FIFO with the FSM in IDLE causes bus_addr to update 2 edges after acceptance (push edge, then pop edge). bus_strb rises SETUP_CYC cycles after that.
- Back-to-back requests: after done, one IDLE cycle, then the next SETUP. Period = 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC cycles.
- Cycle counter: 8 bits, cleared on every state entry.
- Reset mid-transaction: bus_strb drops to 0 at the reset edge; the in-flight request and all queued requests are discarded; done is not pulsed.
- Requests are emitted strictly in FIFO order; no reordering or merging of duplicate addresses.

Optional Feature:
- Macro: STRB_BUS_MASTER_TXCNT_EN.
- Defined:
  - Adds output port tx_count, 16 bits, reset to 0.
  - tx_count increments on every done pulse and wraps from 0xFFFF to 0.
  - Adds input port cnt_clr, 1 bit. When asserted it clears tx_count synchronously; clear takes priority over a simultaneous increment.
- Undefined: neither port exists and no counter logic is generated; all other behaviour is identical.

Test Plan:
- Reset, then a single request req_addr=5'h13 with defaults:
  - bus_addr=5'h13 two edges after acceptance.
  - bus_strb high for exactly 2 cycles, starting 1 cycle after bus_addr changes.
  - done pulses once, on the HOLD cycle; busy then drops.
- Burst of 6 requests 5'h00..5'h05 with req_valid held high, defaults:
  - req_ready drops when fifo_level reaches 4.
  - All 6 requests appear on bus_addr in order, one strobe each.
  - Strobe rising edges are 5 cycles apart.
- HOLD_CYC=0, STROBE_CYC=1, request 5'h1F:
  - bus_strb is a single-cycle pulse and done is asserted in that same cycle.
  - Next IDLE follows immediately.
- rst asserted on the 2nd STROBE cycle with 2 requests queued:
  - Next cycle: bus_strb=0, fifo_level=0, busy=0, no done pulse.
  - No strobe is issued afterwards without new requests.
- Simultaneous push and pop at fifo_level=1 (FSM in IDLE, new request valid):
  - fifo_level stays 1.
  - The popped entry is the older request.
- With STRB_BUS_MASTER_TXCNT_EN defined:
  - 3 transactions give tx_count=3.
  - cnt_clr asserted in the same cycle as the 4th done gives tx_count=0.
